// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: shared defaults and encodings for the word serializer
package word_serializer_pkg;
  localparam int DEF_IN_W = 32;
  localparam int DEF_OUT_W = 8;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;
endpackage

// File: rtl/word_serializer_slice_select.sv
// word_serializer_slice_select: picks beat idx of a word in the requested order
module word_serializer_slice_select
  import word_serializer_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int IDX_W = 2
) (
  input  logic [IN_W-1:0]  word,
  input  logic [IDX_W-1:0] idx,
  input  logic             order,
  output logic [OUT_W-1:0] slice
);
  localparam int N = IN_W / OUT_W;
  logic [IDX_W-1:0] pos;
  assign pos = order == MSB_FIRST ? IDX_W'(N - 1) - idx : idx;
  assign slice = word[pos*OUT_W +: OUT_W];
endmodule

// File: rtl/word_serializer.sv
// word_serializer: streams an IN_W word as IN_W/OUT_W slices over valid/ready
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  localparam int N = IN_W / OUT_W,
  localparam int IDX_W = N > 1 ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);
  if (OUT_W < 1 || IN_W < OUT_W || IN_W % OUT_W != 0) begin : g_bad_width
    $error("word_serializer: IN_W must be a positive multiple of OUT_W");
  end
  state_t state;
  logic [IN_W-1:0] word;
  logic order;
  logic [IDX_W-1:0] cnt;
  logic [OUT_W-1:0] slice;
  logic last, accept;
  word_serializer_slice_select #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) u_sel (
    .word(word),
    .idx(cnt),
    .order(order),
    .slice(slice)
  );
  assign last = state == SEND && cnt == IDX_W'(N - 1);
  // a new word may enter during the last beat so streams have no bubble
  assign in_ready = !reset && (state == IDLE || (last && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state == SEND;
  assign busy = state == SEND;
  assign out_last = last;
  assign out_idx = cnt;
  assign out_data = state == SEND ? slice : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      word <= '0;
      order <= LSB_FIRST;
      cnt <= '0;
    end else if (accept) begin
      state <= SEND;
      word <= in_data;
      order <= msb_first;
      cnt <= '0;
    end else if (state == SEND && out_ready) begin
      state <= last ? IDLE : SEND;
      cnt <= last ? '0 : cnt + IDX_W'(1);
    end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: random and directed checks against a queue-of-beats model
module tb_word_serializer;
  localparam int IW = 32, OW = 8, N = IW / OW;
  typedef struct {logic [OW-1:0] d; int idx; bit last;} beat_t;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic in_valid = 0, in_ready, msb_first = 0, out_valid, out_ready = 0, out_last, busy;
  logic [IW-1:0] in_data = '0;
  logic [OW-1:0] out_data;
  logic [1:0] out_idx;
  logic s_iv = 0, s_rdy, s_m = 0, s_valid, s_r = 0, s_last, s_busy;
  logic [15:0] s_d = '0;
  logic [3:0] s_data;
  logic [1:0] s_idx;
  logic p_iv = 0, p_rdy, p_m = 0, p_valid, p_r = 0, p_last, p_busy;
  logic [7:0] p_d = '0, p_data;
  logic [0:0] p_idx;
  int total = 0, passed = 0;
  beat_t q[$];

  word_serializer #(.IN_W(IW), .OUT_W(OW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .msb_first(msb_first), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy));
  word_serializer #(.IN_W(16), .OUT_W(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(s_iv), .in_ready(s_rdy), .in_data(s_d),
    .msb_first(s_m), .out_valid(s_valid), .out_ready(s_r), .out_data(s_data),
    .out_idx(s_idx), .out_last(s_last), .busy(s_busy));
  word_serializer #(.IN_W(8), .OUT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(p_iv), .in_ready(p_rdy), .in_data(p_d),
    .msb_first(p_m), .out_valid(p_valid), .out_ready(p_r), .out_data(p_data),
    .out_idx(p_idx), .out_last(p_last), .busy(p_busy));

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else passed++;
  endtask

  // drive one cycle from a negedge, compare against the model, then advance the model
  task automatic cycle(bit iv, logic [IW-1:0] d, bit m, bit r);
    bit exp_rdy;
    in_valid = iv; in_data = d; msb_first = m; out_ready = r;
    #1;
    exp_rdy = q.size() == 0 || (q.size() == 1 && r);
    check("out_valid", out_valid, q.size() != 0);
    check("busy", busy, q.size() != 0);
    check("in_ready", in_ready, exp_rdy);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].d);
      check("out_idx", out_idx, q[0].idx);
      check("out_last", out_last, q[0].last);
      if (r) void'(q.pop_front());
    end
    if (iv && exp_rdy)
      for (int b = 0; b < N; b++)
        q.push_back(beat_t'{d: OW'(d >> ((m ? N - 1 - b : b) * OW)), idx: b, last: b == N - 1});
    @(negedge clk);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    bit bp[7] = '{1, 0, 0, 1, 0, 1, 1};
    logic [3:0] e16[4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    @(negedge clk);
    check_zero("reset");
    reset = 0;
    @(negedge clk);
    cycle(1, 32'h12345678, 1, 1);
    for (int i = 0; i < N; i++) cycle(0, 32'h0, 1, 1);
    cycle(1, 32'h12345678, 0, 1);
    for (int i = 0; i < N; i++) cycle(0, 32'hFFFF0000, i[0], 1);
    cycle(1, 32'h12345678, 1, 1);
    foreach (bp[i]) cycle(0, 32'h0, 0, bp[i]);
    cycle(1, 32'hAABBCCDD, 1, 1);
    for (int i = 0; i < 2 * N - 1; i++) cycle(1, 32'h11223344, 0, 1);
    cycle(0, 32'h0, 0, 1);
    cycle(0, 32'h0, 0, 1);
    cycle(1, 32'h12345678, 1, 1);
    cycle(0, 32'h0, 1, 1);
    cycle(0, 32'h0, 1, 1);
    in_valid = 0;
    #2 reset = 1;
    #1 check_zero("async_reset");
    q.delete();
    @(negedge clk);
    reset = 0;
    cycle(1, 32'hCAFEBABE, 1, 1);
    for (int i = 0; i < N + 1; i++) cycle(0, 32'h0, 0, 1);
    repeat (600) cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), $urandom_range(0, 3) != 0);
    repeat (N + 2) cycle(0, 32'h0, 0, 1);
    s_iv = 1; s_d = 16'hABCD; s_m = 1; s_r = 1;
    @(negedge clk);
    s_iv = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("w16_valid", s_valid, 1);
      check("w16_data", s_data, e16[i]);
      check("w16_idx", s_idx, i);
      check("w16_last", s_last, i == 3);
      @(negedge clk);
    end
    #1 check("w16_done", s_valid, 0);
    @(negedge clk);
    p_iv = 1; p_d = 8'h5A; p_r = 1;
    @(negedge clk);
    p_d = 8'hC3;
    #1;
    check("w8_data0", p_data, 8'h5A);
    check("w8_last0", p_last, 1);
    check("w8_ready0", p_rdy, 1);
    @(negedge clk);
    p_iv = 0;
    #1;
    check("w8_data1", p_data, 8'hC3);
    check("w8_last1", p_last, 1);
    check("w8_valid1", p_valid, 1);
    @(negedge clk);
    #1 check("w8_done", p_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/word_serializer.md
# word_serializer

Parametrised wide-to-narrow serializer generalising the fixed 32-to-4×8 byte split: accepts one IN_W-bit word per valid/ready handshake and emits it as N = IN_W/OUT_W consecutive OUT_W-bit slices on a second valid/ready channel. Slice order is MSB-first or LSB-first and is selected per word. It sits between a word-wide datapath (register file / memory read port) and a narrow consumer (byte bus, display driver, UART-style sink).

## Interface
- IN_W, 32, input word width; must be a positive multiple of OUT_W, otherwise elaboration error
- OUT_W, 8, output slice width
- N (localparam), IN_W/OUT_W, slices per word; IDX_W = max(1, $clog2(N))
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream word available
- in_ready  out  1  block can accept a word this cycle
- in_data  in  IN_W  word to serialize
- msb_first  in  1  order for this word, sampled with the word (1: bits [IN_W-1 -: OUT_W] first)
- out_valid  out  1  slice on out_data is valid
- out_ready  in  1  downstream accepts slice
- out_data  out  OUT_W  current slice
- out_idx  out  IDX_W  beat number within word, 0..N-1
- out_last  out  1  current beat is beat N-1
- busy  out  1  word held (state SEND)

## Operation
- FSM states IDLE, SEND; registers: word (IN_W), order bit, beat counter cnt (IDX_W).
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: latch in_data and msb_first, cnt←0, go SEND.
- SEND: out_valid=1, out_idx=cnt, out_last=(cnt==N-1). Slice = word[(N-1-cnt)*OUT_W +: OUT_W] if order=1, else word[cnt*OUT_W +: OUT_W].
- Beat transfer on out_valid&out_ready: cnt←cnt+1 if not last. On last beat: if in_valid, latch the new word, cnt←0, stay SEND; else go IDLE.
- in_ready = (IDLE) | (SEND & out_last & out_ready); forced 0 while reset is high.
- Stall: out_ready=0 holds out_data, out_idx, out_last, out_valid unchanged; in_data/msb_first changes ignored until next accept.
- N=1: every beat is last; the block acts as a one-deep registered pass-through with full throughput.
- Reset (async, any time, including mid-word): state IDLE, cnt=0, word=0, order=0; outputs out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0; the partial word is discarded, not resumed.

## Timing
- Accept at edge k → first slice valid from edge k (visible in cycle k+1); latency 1 cycle.
- Throughput: N beats per word; back-to-back words stream with no bubble when in_valid is held and out_ready=1 (in_ready pulses high during each last beat).
- in_ready has a combinational path from out_ready; all other outputs are decoded from registers only.
- Simultaneous last-beat transfer and new accept: the new word's beat 0 appears on the next cycle; no overlap, no drop.

## Structure
- Shared package/header: default IN_W/OUT_W, FSM state encodings (IDLE=0, SEND=1), order encodings (MSB_FIRST=1, LSB_FIRST=0).
- One sub-module: slice_select (combinational, params IN_W/OUT_W; inputs word, idx, order; output slice). Reused by future deserializer checks.

## Test plan
- IN_W=32/OUT_W=8, 0x12345678, msb_first=1, out_ready=1 → 0x12,0x34,0x56,0x78 on 4 consecutive cycles; out_idx 0..3; out_last only on 0x78.
- Same word, msb_first=0 → 0x78,0x56,0x34,0x12; msb_first toggled mid-word has no effect.
- Backpressure: out_ready pattern 1,0,0,1,0,1,1 → each slice held stable while stalled; exactly 4 beats, order preserved.
- Back-to-back: 0xAABBCCDD then 0x11223344 with in_valid held → 8 beats in 8 consecutive cycles, in_ready high only in IDLE and on the last beat.
- Reset asserted asynchronously after beat 1 → out_valid/out_data/out_idx/out_last drop to 0 immediately; next word 0xCAFEBABE starts at beat 0 (0xCA).
- IN_W=16/OUT_W=4, 0xABCD MSB-first → 0xA,0xB,0xC,0xD; IN_W=OUT_W=8 → 0x5A passes with out_last=1 every beat.
